// File: rtl/apex_pkg.sv
// rtl/apex_pkg.sv - shared state encoding for the APEX exec tracker
package apex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } apex_state_t;

endpackage

// File: rtl/apex_sat_counter.sv
// rtl/apex_sat_counter.sv - saturating cycle counter, loadable to one
module apex_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_to_one,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr_to_one) begin
            count <= CNT_W'(1);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apex_exec_tracker.sv
// rtl/apex_exec_tracker.sv - tracks one clean pass through ER and flags EXEC
module apex_exec_tracker
    import apex_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter bit IRQ_ABORT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      pc,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    input  logic             exec_in,
    input  logic             violation,
    input  logic             irq,
    output logic             exec_flag,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] er_cycles,
    output logic             er_done,
    output logic             er_abort
);

    apex_state_t state_q;
    apex_state_t state_d;
    logic        prev_max;
    logic        in_er;
    logic        start;
    logic        meta_bad;
    logic        bad;
    logic        done_d;
    logic        abort_d;
    logic        cnt_clr;
    logic        cnt_inc;

    assign in_er    = (pc >= ER_min) && (pc <= ER_max);
    assign start    = (pc == ER_min) && exec_in && !violation;
    assign meta_bad = !exec_in || violation;
    // irq only matters while the code inside ER is executing
    assign bad      = meta_bad || (IRQ_ABORT && irq);
    assign state    = state_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE, FAIL: begin
                if (start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (bad) begin
                    state_d = FAIL;
                    abort_d = 1'b1;
                end else if (!in_er && prev_max) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (!in_er) begin
                    state_d = FAIL;
                    abort_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (meta_bad) begin
                    state_d = FAIL;
                    abort_d = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            exec_flag <= 1'b0;
            er_done   <= 1'b0;
            er_abort  <= 1'b0;
            prev_max  <= 1'b0;
        end else begin
            state_q   <= state_d;
            exec_flag <= (state_d == DONE);
            er_done   <= done_d;
            er_abort  <= abort_d;
            prev_max  <= (pc == ER_max);
        end
    end

    apex_sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycles (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_to_one (cnt_clr),
        .inc        (cnt_inc),
        .count      (er_cycles)
    );

endmodule
